// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor PWM driver: speed width, period, duty mapping.
package mtr_pkg;

    localparam int unsigned SPD_W      = 11;
    localparam int unsigned PWM_PERIOD = 2048;
    localparam logic [SPD_W-1:0] DUTY_ZERO = 11'h400;
    localparam logic [SPD_W-1:0] CNT_LAST  = SPD_W'(PWM_PERIOD - 1);
    localparam logic [SPD_W-1:0] CNT_PRE   = SPD_W'(PWM_PERIOD - 2);

    typedef enum logic [1:0] {DEAD, ON_HI, ON_LO} dt_state_t;

    // Signed speed -> unsigned duty by flipping the sign bit (spd + 1024).
    function automatic logic [SPD_W-1:0] spd_to_duty(input logic signed [SPD_W-1:0] spd);
        return SPD_W'(spd) ^ DUTY_ZERO;
    endfunction

endpackage

// File: rtl/pwm_dt_chan.sv
// One H-bridge half-pair: turns a raw PWM level into complementary gate drives with dead time.
module pwm_dt_chan
    import mtr_pkg::*;
#(
    parameter int unsigned DEADTIME = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pwm1,
    output logic pwm2
);

    localparam logic [7:0] DT_LAST = 8'(DEADTIME - 1);

    dt_state_t  state;
    logic [7:0] dcnt;
    logic       tgt;

    // Gate outputs are registered alongside the state so they always equal its decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DEAD;
            dcnt  <= 8'd0;
            tgt   <= 1'b0;
            pwm1  <= 1'b0;
            pwm2  <= 1'b0;
        end else if (!en) begin
            state <= DEAD;
            dcnt  <= 8'd0;
            tgt   <= raw;
            pwm1  <= 1'b0;
            pwm2  <= 1'b0;
        end else begin
            case (state)
                ON_HI: begin
                    if (!raw) begin
                        state <= DEAD;
                        tgt   <= 1'b0;
                        dcnt  <= 8'd0;
                        pwm1  <= 1'b0;
                    end
                end
                ON_LO: begin
                    if (raw) begin
                        state <= DEAD;
                        tgt   <= 1'b1;
                        dcnt  <= 8'd0;
                        pwm2  <= 1'b0;
                    end
                end
                default: begin
                    // A raw change while waiting restarts the full dead window.
                    if (raw != tgt) begin
                        tgt  <= raw;
                        dcnt <= 8'd0;
                    end else if (dcnt == DT_LAST) begin
                        state <= tgt ? ON_HI : ON_LO;
                        pwm1  <= tgt;
                        pwm2  <= !tgt;
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Dual-channel motor PWM driver: shared period counter, boundary-loaded duties, dead-time channels.
module mtr_pwm_drv
    import mtr_pkg::*;
#(
    parameter int unsigned DEADTIME = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drv_en,
    input  logic signed [SPD_W-1:0] lft_spd,
    input  logic signed [SPD_W-1:0] rght_spd,
    output logic                    lft_pwm1,
    output logic                    lft_pwm2,
    output logic                    rght_pwm1,
    output logic                    rght_pwm2,
    output logic                    duty_upd
);

    logic [SPD_W-1:0] cnt;
    logic [SPD_W-1:0] duty_l;
    logic [SPD_W-1:0] duty_r;
    logic             raw_l;
    logic             raw_r;

    // Period counter and double-buffered duties; new duties take effect from cnt 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            duty_l   <= DUTY_ZERO;
            duty_r   <= DUTY_ZERO;
            duty_upd <= 1'b0;
        end else begin
            cnt      <= cnt + SPD_W'(1);
            duty_upd <= (cnt == CNT_PRE);
            if (cnt == CNT_LAST) begin
                duty_l <= spd_to_duty(lft_spd);
                duty_r <= spd_to_duty(rght_spd);
            end
        end
    end

    assign raw_l = (cnt < duty_l);
    assign raw_r = (cnt < duty_r);

    pwm_dt_chan #(.DEADTIME(DEADTIME)) u_chan_l (
        .clk  (clk),
        .rst  (rst),
        .en   (drv_en),
        .raw  (raw_l),
        .pwm1 (lft_pwm1),
        .pwm2 (lft_pwm2)
    );

    pwm_dt_chan #(.DEADTIME(DEADTIME)) u_chan_r (
        .clk  (clk),
        .rst  (rst),
        .en   (drv_en),
        .raw  (raw_r),
        .pwm1 (rght_pwm1),
        .pwm2 (rght_pwm2)
    );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv: per-period high-time counts against hand-derived values.
module tb_mtr_pwm_drv;

    logic               clk;
    logic               rst;
    logic               drv_en;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lft_pwm1;
    logic               lft_pwm2;
    logic               rght_pwm1;
    logic               rght_pwm2;
    logic               duty_upd;

    logic [10:0] m_cnt;

    int n_checks;
    int n_errors;
    int c_l1, c_l2, c_r1, c_r2, c_upd;
    int both_hi;
    int upd_err;

    mtr_pwm_drv #(.DEADTIME(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .drv_en    (drv_en),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lft_pwm1  (lft_pwm1),
        .lft_pwm2  (lft_pwm2),
        .rght_pwm1 (rght_pwm1),
        .rght_pwm2 (rght_pwm2),
        .duty_upd  (duty_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference period counter; at a falling edge it equals the DUT cnt of that cycle.
    always @(posedge clk) begin
        if (rst) m_cnt <= 11'd0;
        else     m_cnt <= m_cnt + 11'd1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample n cycles at falling edges and count high cycles per output.
    task automatic measure(input int n);
        c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; c_upd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (lft_pwm1)  c_l1++;
            if (lft_pwm2)  c_l2++;
            if (rght_pwm1) c_r1++;
            if (rght_pwm2) c_r2++;
            if (duty_upd)  c_upd++;
            if ((lft_pwm1 && lft_pwm2) || (rght_pwm1 && rght_pwm2)) both_hi++;
            if (duty_upd !== (m_cnt == 11'd2047)) upd_err++;
        end
    endtask

    initial begin
        int s_l1, s_l2;
        n_checks = 0; n_errors = 0; both_hi = 0; upd_err = 0;
        rst = 1'b1; drv_en = 1'b1;
        lft_spd = 11'sd500; rght_spd = 11'sd500;

        // Reset held 3 clocks: everything low
        repeat (3) @(negedge clk);
        check("rst_outs", int'({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2}), 0);
        check("rst_upd", int'(duty_upd), 0);
        rst = 1'b0;

        // First period after reset still uses duty 1024 despite spd=500
        measure(2047);
        check("p1_l1", c_l1, 992);
        check("p1_l2", c_l2, 991);
        check("p1_r1", c_r1, 992);
        check("p1_upd", c_upd, 1);

        // Left 0 (50%), right full forward
        lft_spd = 11'sd0; rght_spd = 11'sd1023;
        measure(2048);
        check("p2_l1", c_l1, 992);
        check("p2_l2", c_l2, 992);
        check("p2_r1", c_r1, 2015);
        check("p2_r2", c_r2, 1);
        for (int p = 0; p < 2; p++) begin
            measure(2048);
            check("p34_l1", c_l1, 992);
            check("p34_l2", c_l2, 992);
            check("p34_r1", c_r1, 2015);
            check("p34_r2", c_r2, 0);
        end

        // Full reverse on the left
        lft_spd = 11'(-1024);
        measure(2048);
        check("rev_l1", c_l1, 0);
        check("rev_l2", c_l2, 2048);
        check("rev_r1", c_r1, 2015);

        // Mid-period speed change is held off until the boundary
        lft_spd = 11'sd0;
        measure(501);
        s_l1 = c_l1; s_l2 = c_l2;
        lft_spd = 11'sd512;
        measure(1547);
        check("mid_l1", s_l1 + c_l1, 992);
        check("mid_l2", s_l2 + c_l2, 992);
        measure(2048);
        check("new_l1", c_l1, 1504);
        check("new_l2", c_l2, 480);

        // Disable at cnt 100, re-enable at cnt 300, reset at cnt 700
        measure(101);
        drv_en = 1'b0;
        measure(1);
        check("dis_next", c_l1 + c_l2 + c_r1 + c_r2, 0);
        measure(199);
        check("dis_hold", c_l1 + c_l2 + c_r1 + c_r2, 0);
        drv_en = 1'b1;
        measure(31);
        check("en_dead", c_l1 + c_l2 + c_r1 + c_r2, 0);
        measure(1);
        check("en_l1", c_l1, 1);
        check("en_r1", c_r1, 1);
        check("en_pwm2", c_l2 + c_r2, 0);
        measure(368);
        rst = 1'b1;
        measure(1);
        check("mrst_outs", c_l1 + c_l2 + c_r1 + c_r2, 0);
        rst = 1'b0;
        measure(2047);
        check("post_l1", c_l1, 992);
        check("post_l2", c_l2, 991);
        check("post_r1", c_r1, 992);
        check("post_r2", c_r2, 991);
        check("post_upd", c_upd, 1);

        check("never_both", both_hi, 0);
        check("upd_align", upd_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
